// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, bubble encoding, IF state type
// and the branch/jump opcodes decoded in ID/EX.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'd0;

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } if_state_t;

    localparam logic [5:0] OP_BEZ = 6'b101000;
    localparam logic [5:0] OP_BNE = 6'b101001;
    localparam logic [5:0] OP_JMP = 6'b101010;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Generic pipeline register carrying {pc, instr, valid} with flush > load > hold
// priority; reused for the other stage boundaries.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned       W      = WORD_W,
    parameter logic [W-1:0]      BUBBLE = NOP_WORD
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         flush,
    input  logic [W-1:0] d_pc,
    input  logic [W-1:0] d_instr,
    output logic [W-1:0] q_pc,
    output logic [W-1:0] q_instr,
    output logic         q_valid
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_pc    <= '0;
            q_instr <= BUBBLE;
            q_valid <= 1'b0;
        end else if (flush) begin
            q_pc    <= '0;
            q_instr <= BUBBLE;
            q_valid <= 1'b0;
        end else if (load) begin
            q_pc    <= d_pc;
            q_instr <= d_instr;
            q_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, boot/run/frozen FSM, redirect and
// out-of-range bubbling. Define IF_PERF_CNT_EN to build fetch/bubble counters.
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] LAST_PC  = 32'd228,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    if_state_t   state;
    if_state_t   state_next;
    logic        in_range;
    logic        reg_load;
    logic        reg_flush;

    assign pc_plus4  = pc + 32'd4;
    assign in_range  = (pc <= LAST_PC);
    assign imem_addr = pc;

    // Boot and frozen-release cycles fetch exactly like run; the FSM records
    // context but does not alter the datapath priority.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        reg_load   = 1'b0;
        reg_flush  = 1'b0;
        if (branch_taken) begin
            pc_next    = {branch_target[31:2], 2'b00};
            reg_flush  = 1'b1;
            state_next = S_RUN;
        end else if (freeze) begin
            state_next = S_FROZEN;
        end else begin
            pc_next    = pc_plus4;
            state_next = S_RUN;
            if (in_range) begin
                reg_load = 1'b1;
            end else begin
                reg_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= S_BOOT;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    if_id_reg #(
        .W      (32),
        .BUBBLE (NOP_WORD)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (reg_load),
        .flush   (reg_flush),
        .d_pc    (pc_plus4),
        .d_instr (imem_data),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr),
        .q_valid (if_id_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_q;
    logic [31:0] bubble_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (reg_load && (fetch_q != '1)) begin
                fetch_q <= fetch_q + 32'd1;
            end
            if (reg_flush && (bubble_q != '1)) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign fetch_count  = fetch_q;
    assign bubble_count = bubble_q;
`else
    assign fetch_count  = '0;
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage against a small combinational
// program image; counter checks follow the IF_PERF_CNT_EN build setting.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [31:0] bubble_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (32'd0),
        .LAST_PC  (32'd228),
        .NOP_WORD (32'd0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count),
        .bubble_count  (bubble_count)
    );

    // Program image: two known words, an address-tagged filler elsewhere,
    // and garbage beyond the last valid address.
    function automatic logic [31:0] w(input logic [31:0] a);
        if (a > 32'd228)       return 32'hDEADBEEF;
        else if (a == 32'd0)   return 32'h8020000A;
        else if (a == 32'd120) return 32'h29034800;
        else                   return 32'hA0000000 | a;
    endfunction

    always_comb imem_data = w(imem_addr);

    typedef struct {
        bit          rst;
        bit          frz;
        bit          br;
        logic [31:0] tgt;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          chk_pc;
        logic [31:0] e_fc;
        logic [31:0] e_bc;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] fc_m = 0;
    logic [31:0] bc_m = 0;

    task automatic add(input bit r, input bit f, input bit b, input logic [31:0] t,
                       input logic [31:0] ea, input bit ev, input logic [31:0] ei,
                       input logic [31:0] ep, input bit cp);
        vec_t v;
        if (!r) begin
            fc_m = 0; bc_m = 0;
        end else if (b) begin
            bc_m++;
        end else if (!f) begin
            if (ev) fc_m++; else bc_m++;
        end
        v.rst = r; v.frz = f; v.br = b; v.tgt = t;
        v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.chk_pc = cp;
        v.e_fc = fc_m; v.e_bc = bc_m;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_counters(input string tag, input logic [31:0] efc, input logic [31:0] ebc);
`ifdef IF_PERF_CNT_EN
        chk({tag, " fetch_count"}, fetch_count, efc);
        chk({tag, " bubble_count"}, bubble_count, ebc);
`else
        chk({tag, " fetch_count"}, fetch_count, 32'd0);
        chk({tag, " bubble_count"}, bubble_count, 32'd0);
        if (efc == 32'hFFFF_FFFF || ebc == 32'hFFFF_FFFF) $display("note: counter model at limit");
`endif
    endtask

    task automatic step(input bit r, input bit f, input bit b, input logic [31:0] t);
        rst_n = r; freeze = f; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_target = '0;

        // Boot, then straight-line fetch and a 3-cycle freeze at imem_addr 12.
        add(1, 0, 0, 0, 32'd4,  1, w(0), 32'd4, 1);
        add(1, 0, 0, 0, 32'd8,  1, w(4), 32'd8, 1);
        add(1, 0, 0, 0, 32'd12, 1, w(8), 32'd12, 1);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 32'd12, 1, w(8), 32'd12, 1);
        add(1, 0, 0, 0, 32'd16, 1, w(12), 32'd16, 1);
        for (int a = 16; a <= 156; a += 4) add(1, 0, 0, 0, a + 4, 1, w(a), a + 4, 1);
        // Redirect from 160 to 120.
        add(1, 0, 1, 32'd120, 32'd120, 0, 32'd0, 32'd0, 1);
        add(1, 0, 0, 0, 32'd124, 1, 32'h29034800, 32'd124, 1);
        // Branch beats freeze; misaligned target is aligned down.
        add(1, 1, 1, 32'h2A, 32'h28, 0, 32'd0, 32'd0, 1);
        add(1, 1, 0, 0, 32'h28, 0, 32'd0, 32'd0, 1);
        add(1, 0, 0, 0, 32'h2C, 1, w(32'h28), 32'h2C, 1);
        for (int a = 44; a <= 228; a += 4) add(1, 0, 0, 0, a + 4, 1, w(a), a + 4, 1);
        // Beyond LAST_PC: bubbles while pc keeps advancing.
        add(1, 0, 0, 0, 32'd236, 0, 32'd0, 32'd0, 0);
        add(1, 0, 0, 0, 32'd240, 0, 32'd0, 32'd0, 0);
        add(1, 0, 1, 32'd100, 32'd100, 0, 32'd0, 32'd0, 1);
        // Mid-run reset at 100, then five clean fetches.
        add(0, 0, 0, 0, 32'd0, 0, 32'd0, 32'd0, 1);
        for (int a = 0; a <= 16; a += 4) add(1, 0, 0, 0, a + 4, 1, w(a), a + 4, 1);

        step(0, 0, 0, 0);
        chk("reset imem_addr", imem_addr, 32'd0);
        chk("reset valid", {31'd0, if_id_valid}, 32'd0);
        chk("reset instr", if_id_instr, 32'd0);
        chk("reset if_id_pc", if_id_pc, 32'd0);
        check_counters("reset", 32'd0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            step(vecs[i].rst, vecs[i].frz, vecs[i].br, vecs[i].tgt);
            chk({tag, " imem_addr"}, imem_addr, vecs[i].e_addr);
            chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
            chk({tag, " instr"}, if_id_instr, vecs[i].e_instr);
            if (vecs[i].chk_pc) chk({tag, " if_id_pc"}, if_id_pc, vecs[i].e_pc);
            check_counters(tag, vecs[i].e_fc, vecs[i].e_bc);
        end

        // Redirect during the boot cycle itself.
        step(0, 0, 0, 0);
        step(1, 0, 1, 32'h43);
        chk("boot-branch imem_addr", imem_addr, 32'h40);
        chk("boot-branch valid", {31'd0, if_id_valid}, 32'd0);
        check_counters("boot-branch", 32'd0, 32'd1);
        step(1, 0, 0, 0);
        chk("boot-branch instr", if_id_instr, w(32'h40));
        chk("boot-branch if_id_pc", if_id_pc, 32'h44);
        // Freeze right after reset holds the reset PC and the empty register.
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("boot-freeze imem_addr", imem_addr, 32'd0);
        chk("boot-freeze valid", {31'd0, if_id_valid}, 32'd0);
        step(1, 0, 0, 0);
        chk("boot-freeze release instr", if_id_instr, 32'h8020000A);
        check_counters("boot-freeze", 32'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
